// File: rtl/myy_mul_pkg.sv
// Shared constants for the multiplier control/datapath interface.
package myy_mul_pkg;

  localparam int unsigned OPW = 8;
  localparam int unsigned PW  = 9;
  localparam int unsigned RW  = 16;
  localparam int unsigned YW  = 10;
  localparam int unsigned XW  = 3;

  // Control word bit positions
  localparam int unsigned Y_LDA  = 0;
  localparam int unsigned Y_LDB  = 1;
  localparam int unsigned Y_CLRP = 2;
  localparam int unsigned Y_ADD  = 3;
  localparam int unsigned Y_SUB  = 4;
  localparam int unsigned Y_SHR  = 5;
  localparam int unsigned Y_LDR  = 6;
  localparam int unsigned Y_CLRR = 7;
  localparam int unsigned Y_SETV = 8;
  localparam int unsigned Y_CLRV = 9;

  // Condition vector bit positions
  localparam int unsigned X_F1 = 0;
  localparam int unsigned X_F2 = 1;
  localparam int unsigned X_F3 = 2;

endpackage : myy_mul_pkg

// File: rtl/oper_block_mul_addsub9.sv
// Combinational 9-bit adder/subtractor, modulo 2^9.
module addsub9
  import myy_mul_pkg::*;
(
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  input  logic          sub,
  output logic [PW-1:0] sum_c
);

  // a - b when sub is set, otherwise a + b
  always_comb begin
    sum_c = PW'(a + b);
    if (sub) begin
      sum_c = PW'(a - b);
    end
  end

endmodule : addsub9

// File: rtl/oper_block_mul.sv
// Datapath for signed 8x8 shift-add multiplication under microprogram control.
module oper_block_mul
  import myy_mul_pkg::*;
(
  input  logic            clk,
  input  logic            set,
  input  logic [YW-1:0]   y,
  input  logic [OPW-1:0]  din_a,
  input  logic [OPW-1:0]  din_b,
  output logic [XW-1:0]   x,
  output logic [RW-1:0]   res,
  output logic            valid
);

  logic [OPW-1:0] a_q;
  logic [OPW-1:0] b_q;
  logic [PW-1:0]  p_q;
  logic [RW-1:0]  r_q;
  logic           v_q;

  logic [PW-1:0]  arith_c;
  logic [PW-1:0]  p_arith;
  logic [PW-1:0]  p_next;
  logic [OPW-1:0] b_next;

  addsub9 u_addsub9 (
    .a     (p_q),
    .b     ({a_q[OPW-1], a_q}),
    .sub   (y[Y_SUB]),
    .sum_c (arith_c)
  );

  // P/B next values: arithmetic first, then shift; clear and load take priority
  always_comb begin
    p_arith = p_q;
    if (y[Y_ADD] || y[Y_SUB]) begin
      p_arith = arith_c;
    end
    p_next = p_arith;
    if (y[Y_SHR]) begin
      p_next = {p_arith[PW-1], p_arith[PW-1:1]};
    end
    if (y[Y_CLRP]) begin
      p_next = '0;
    end
    b_next = b_q;
    if (y[Y_SHR]) begin
      b_next = {p_arith[0], b_q[OPW-1:1]};
    end
    if (y[Y_LDB]) begin
      b_next = din_b;
    end
  end

  // Operand A register
  always_ff @(posedge clk) begin
    if (set) begin
      a_q <= '0;
    end else if (y[Y_LDA]) begin
      a_q <= din_a;
    end
  end

  // Partial product P and multiplier/low product B
  always_ff @(posedge clk) begin
    if (set) begin
      p_q <= '0;
      b_q <= '0;
    end else begin
      p_q <= p_next;
      b_q <= b_next;
    end
  end

  // Result register R; clear wins over load
  always_ff @(posedge clk) begin
    if (set) begin
      r_q <= '0;
    end else if (y[Y_CLRR]) begin
      r_q <= '0;
    end else if (y[Y_LDR]) begin
      r_q <= {p_q[OPW-1:0], b_q};
    end
  end

  // Valid flag; clear wins over set
  always_ff @(posedge clk) begin
    if (set) begin
      v_q <= 1'b0;
    end else if (y[Y_CLRV]) begin
      v_q <= 1'b0;
    end else if (y[Y_SETV]) begin
      v_q <= 1'b1;
    end
  end

  // Branch conditions straight from the registers
  always_comb begin
    x       = '0;
    x[X_F1] = b_q[0];
    x[X_F2] = (a_q == '0) || (b_q == '0);
    x[X_F3] = p_q[PW-1];
  end

  assign res   = r_q;
  assign valid = v_q;

endmodule : oper_block_mul

// File: tb/tb_oper_block_mul.sv
// Scoreboard bench for oper_block_mul acting as its control unit.
module tb_oper_block_mul;
  import myy_mul_pkg::*;

  localparam logic [YW-1:0] LDA  = YW'(1 << Y_LDA);
  localparam logic [YW-1:0] LDB  = YW'(1 << Y_LDB);
  localparam logic [YW-1:0] CLRP = YW'(1 << Y_CLRP);
  localparam logic [YW-1:0] ADD  = YW'(1 << Y_ADD);
  localparam logic [YW-1:0] SUB  = YW'(1 << Y_SUB);
  localparam logic [YW-1:0] SHR  = YW'(1 << Y_SHR);
  localparam logic [YW-1:0] LDR  = YW'(1 << Y_LDR);
  localparam logic [YW-1:0] CLRR = YW'(1 << Y_CLRR);
  localparam logic [YW-1:0] SETV = YW'(1 << Y_SETV);
  localparam logic [YW-1:0] CLRV = YW'(1 << Y_CLRV);

  logic            clk = 1'b0;
  logic            set;
  logic [YW-1:0]   y;
  logic [OPW-1:0]  din_a;
  logic [OPW-1:0]  din_b;
  logic [XW-1:0]   x;
  logic [RW-1:0]   res;
  logic            valid;

  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] sb_q[$];

  oper_block_mul dut (
    .clk   (clk),
    .set   (set),
    .y     (y),
    .din_a (din_a),
    .din_b (din_b),
    .x     (x),
    .res   (res),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one control word for one edge, sample just after it
  task automatic step(input logic [YW-1:0] yv, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    y     = yv;
    din_a = a;
    din_b = b;
    @(posedge clk);
    #1;
    y = '0;
  endtask

  function automatic logic [RW-1:0] ref_mul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic signed [RW-1:0] sa;
    logic signed [RW-1:0] sb;
    sa = $signed({{8{a[7]}}, a});
    sb = $signed({{8{b[7]}}, b});
    return RW'(sa * sb);
  endfunction

  // Run the full microprogram; steps == 8 means no abort
  task automatic run_mul(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input string tag);
    int cyc;
    int guard;
    logic [RW-1:0] e;
    sb_q.push_back(ref_mul(a, b));
    cyc = 0;
    step(LDA | LDB | CLRP | CLRV, a, b);
    cyc++;
    chk({tag, "_vlow"}, RW'(valid), 16'h0000);
    for (int i = 0; i < 7; i++) begin
      step(SHR | (x[X_F1] ? ADD : YW'(0)), '0, '0);
      cyc++;
    end
    step(SHR | (x[X_F1] ? SUB : YW'(0)), '0, '0);
    cyc++;
    step(LDR | SETV, '0, '0);
    cyc++;
    guard = 0;
    while (!valid && guard < 4) begin
      step('0, '0, '0);
      cyc++;
      guard++;
    end
    chk({tag, "_valid"}, RW'(valid), 16'h0001);
    chk({tag, "_lat"}, RW'(cyc), 16'd10);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_res"}, res, e);
    end else begin
      chk({tag, "_sb_empty"}, 16'h0001, 16'h0000);
    end
  endtask

  initial begin
    set   = 1'b1;
    y     = '1;
    din_a = 8'hA5;
    din_b = 8'h5A;
    @(posedge clk);
    #1;
    set = 1'b0;
    y   = '0;
    chk("rst_res", res, 16'h0000);
    chk("rst_valid", RW'(valid), 16'h0000);
    chk("rst_x", RW'(x), 16'h0002);

    run_mul(8'd3,  8'd5,  "m3x5");
    run_mul(8'hFD, 8'd5,  "mn3x5");
    run_mul(8'd5,  8'hFD, "m5xn3");
    run_mul(8'h80, 8'h80, "mn128");
    for (int k = 0; k < 6; k++) begin
      run_mul(OPW'($urandom), OPW'($urandom), "mrnd");
    end

    // zero detection on f2
    step(LDA, 8'd0, 8'd0);
    chk("z_a0", RW'(x[X_F2]), 16'h0001);
    step(LDA | LDB, 8'd7, 8'd0);
    chk("z_b0", RW'(x[X_F2]), 16'h0001);
    step(LDB, 8'd0, 8'd1);
    chk("z_clr", RW'(x[X_F2]), 16'h0000);
    chk("z_f1", RW'(x[X_F1]), 16'h0001);

    // simultaneous micro-op priorities
    step(LDA | LDB | CLRP, 8'd1, 8'h55);
    step(ADD | SUB, '0, '0);
    chk("sub_wins_f3", RW'(x[X_F3]), 16'h0001);
    step(LDR, '0, '0);
    chk("sub_wins_r", res, 16'hFF55);
    step(LDB | SHR, '0, 8'h0F);
    step(LDR, '0, '0);
    chk("ldb_wins_r", res, 16'hFF0F);
    step(CLRP | ADD, '0, '0);
    chk("clrp_f3", RW'(x[X_F3]), 16'h0000);
    step(LDR, '0, '0);
    chk("clrp_r", res, 16'h000F);
    step(SETV, '0, '0);
    chk("setv", RW'(valid), 16'h0001);
    step(SETV | CLRV, '0, '0);
    chk("clrv_wins", RW'(valid), 16'h0000);
    step('0, '0, '0);
    chk("nop_res", res, 16'h000F);
    step(LDR | CLRR, '0, '0);
    chk("clrr_wins", res, 16'h0000);

    // reset in the middle of a multiply, after a result is held
    run_mul(8'd5, 8'hFD, "pre");
    step(LDA | LDB | CLRP | CLRV, 8'hFD, 8'hFB);
    for (int i = 0; i < 3; i++) begin
      step(SHR | (x[X_F1] ? ADD : YW'(0)), '0, '0);
    end
    set = 1'b1;
    step(SETV | LDR | ADD | SHR, 8'h11, 8'h22);
    set = 1'b0;
    chk("mid_rst_res", res, 16'h0000);
    chk("mid_rst_valid", RW'(valid), 16'h0000);
    chk("mid_rst_x", RW'(x), 16'h0002);
    run_mul(8'd7, 8'd9, "m7x9");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_oper_block_mul
